pkt_tx_arbiter: RTL and testbench

//  Two-port, packet-granular round-robin arbiter that drains two FWFT packet FIFOs
//  (pkt_fifo-style read sides) onto one GMII-style transmit byte stream.

---
 rtl/pkt_tx_arbiter_if.sv | 38 +++
 rtl/pkt_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_pkt_tx_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_tx_arbiter_if.sv
// rtl/pkt_tx_arbiter_if.sv - FIFO read sides and transmit stream of the packet arbiter
interface pkt_tx_arbiter_if;
   logic       p0_avail;
   logic       p0_empty;
   logic [7:0] p0_data;
   logic       p0_er;
   logic       p0_last;
   logic       p0_rd_en;
   logic       p1_avail;
   logic       p1_empty;
   logic [7:0] p1_data;
   logic       p1_er;
   logic       p1_last;
   logic       p1_rd_en;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_er;
   logic       grant;
   logic       busy;
   logic       underrun;
   logic       jabber;

   // arbiter side: consumes both FIFOs, drives the shared transmit stream
   modport master (
      input  p0_avail, p0_empty, p0_data, p0_er, p0_last,
      input  p1_avail, p1_empty, p1_data, p1_er, p1_last,
      output p0_rd_en, p1_rd_en,
      output tx_data, tx_en, tx_er, grant, busy, underrun, jabber
   );

   // environment side: the per-port FIFOs and the PHY
   modport slave (
      output p0_avail, p0_empty, p0_data, p0_er, p0_last,
      output p1_avail, p1_empty, p1_data, p1_er, p1_last,
      input  p0_rd_en, p1_rd_en,
      input  tx_data, tx_en, tx_er, grant, busy, underrun, jabber
   );
endinterface

// File: rtl/pkt_tx_arbiter.sv
// rtl/pkt_tx_arbiter.sv - two-port packet round-robin arbiter onto a GMII-style byte stream
module pkt_tx_arbiter #(
   parameter int IFG     = 12,
   parameter int MAX_LEN = 1522,
   parameter int CNT_W   = 11
) (
   input  logic              clk,
   input  logic              rst,
   pkt_tx_arbiter_if.master  bus
);

   localparam int GAP_W = (IFG > 2) ? $clog2(IFG) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IFG - 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] byte_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             jab_done;
   logic [7:0]       tx_data_q;
   logic             tx_en_q;
   logic             tx_er_q;
   logic             grant_q;
   logic             busy_q;
   logic             underrun_q;
   logic             jabber_q;

   logic             head_empty;
   logic [7:0]       head_data;
   logic             head_er;
   logic             head_last;
   logic             pop;

   // present the FWFT head of whichever port currently owns the stream
   always_comb begin
      head_empty = bus.p0_empty;
      head_data  = bus.p0_data;
      head_er    = bus.p0_er;
      head_last  = bus.p0_last;
      if (grant_q) begin
         head_empty = bus.p1_empty;
         head_data  = bus.p1_data;
         head_er    = bus.p1_er;
         head_last  = bus.p1_last;
      end
   end

   // pop whenever the owning FIFO has a byte; reset kills the pop in the same cycle
   assign pop          = (state == ST_SEND) && !head_empty && !rst;
   assign bus.p0_rd_en = pop && !grant_q;
   assign bus.p1_rd_en = pop &&  grant_q;

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_en    = tx_en_q;
   assign bus.tx_er    = tx_er_q;
   assign bus.grant    = grant_q;
   assign bus.busy     = busy_q;
   assign bus.underrun = underrun_q;
   assign bus.jabber   = jabber_q;

   // packet FSM: arbitrate in IDLE, stream one whole packet in SEND, hold the line quiet in GAP
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         gap_cnt    <= '0;
         jab_done   <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         grant_q    <= 1'b1;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         jabber_q   <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         jabber_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx_en_q   <= 1'b0;
               tx_er_q   <= 1'b0;
               tx_data_q <= 8'h00;
               byte_cnt  <= '0;
               jab_done  <= 1'b0;
               if (bus.p0_avail && bus.p1_avail) begin
                  grant_q <= ~grant_q;
               end else if (bus.p0_avail) begin
                  grant_q <= 1'b0;
               end else if (bus.p1_avail) begin
                  grant_q <= 1'b1;
               end
               if (bus.p0_avail || bus.p1_avail) begin
                  state  <= ST_SEND;
                  busy_q <= 1'b1;
               end
            end
            ST_SEND: begin
               tx_en_q <= 1'b1;
               if (pop) begin
                  tx_data_q <= head_data;
                  tx_er_q   <= head_er | (byte_cnt >= MAX_CNT);
                  if (byte_cnt != CNT_SAT) begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
                  if ((byte_cnt == MAX_CNT) && !jab_done) begin
                     jabber_q <= 1'b1;
                     jab_done <= 1'b1;
                  end
                  if (head_last) begin
                     state   <= ST_GAP;
                     gap_cnt <= GAP_INIT;
                  end
               end else begin
                  tx_data_q  <= 8'h00;
                  tx_er_q    <= 1'b1;
                  underrun_q <= 1'b1;
               end
            end
            ST_GAP: begin
               tx_en_q   <= 1'b0;
               tx_er_q   <= 1'b0;
               tx_data_q <= 8'h00;
               if (gap_cnt == '0) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// tb/tb_pkt_tx_arbiter.sv - randomized check of two arbiter instances against a packet-level model
module tb_pkt_tx_arbiter;

   localparam int IFG_A = 12;
   localparam int MAX_A = 8;
   localparam int IFG_B = 2;
   localparam int MAX_B = 1522;
   localparam int N_CYC = 4000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // free-running transmit clock
   always #5 clk = ~clk;

   pkt_tx_arbiter_if ifa ();
   pkt_tx_arbiter_if ifb ();

   pkt_tx_arbiter #(.IFG(IFG_A), .MAX_LEN(MAX_A), .CNT_W(11)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.master)
   );

   pkt_tx_arbiter #(.IFG(IFG_B), .MAX_LEN(MAX_B), .CNT_W(11)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.master)
   );

   logic [1:0] avail_v [2];
   logic [1:0] empty_v [2];
   logic [1:0] er_v    [2];
   logic [1:0] last_v  [2];
   logic [7:0] data_v  [2][2];

   assign ifa.p0_avail = avail_v[0][0];
   assign ifa.p1_avail = avail_v[0][1];
   assign ifa.p0_empty = empty_v[0][0];
   assign ifa.p1_empty = empty_v[0][1];
   assign ifa.p0_er    = er_v[0][0];
   assign ifa.p1_er    = er_v[0][1];
   assign ifa.p0_last  = last_v[0][0];
   assign ifa.p1_last  = last_v[0][1];
   assign ifa.p0_data  = data_v[0][0];
   assign ifa.p1_data  = data_v[0][1];
   assign ifb.p0_avail = avail_v[1][0];
   assign ifb.p1_avail = avail_v[1][1];
   assign ifb.p0_empty = empty_v[1][0];
   assign ifb.p1_empty = empty_v[1][1];
   assign ifb.p0_er    = er_v[1][0];
   assign ifb.p1_er    = er_v[1][1];
   assign ifb.p0_last  = last_v[1][0];
   assign ifb.p1_last  = last_v[1][1];
   assign ifb.p0_data  = data_v[1][0];
   assign ifb.p1_data  = data_v[1][1];

   wire [1:0]  rd_a  = {ifa.p1_rd_en, ifa.p0_rd_en};
   wire [1:0]  rd_b  = {ifb.p1_rd_en, ifb.p0_rd_en};
   wire [13:0] obs_a = {ifa.tx_data, ifa.tx_en, ifa.tx_er, ifa.grant, ifa.busy, ifa.underrun, ifa.jabber};
   wire [13:0] obs_b = {ifb.tx_data, ifb.tx_en, ifb.tx_er, ifb.grant, ifb.busy, ifb.underrun, ifb.jabber};

   // FIFO contents per (dut*2+port): {last, er, data}
   logic [9:0] fq [4][$];
   int         pkt_cnt  [4];
   int         owner    [2];
   int         nb       [2];
   int         gap_left [2];
   logic       grant_m  [2];
   logic [13:0] exp_obs [2];
   logic [1:0]  exp_rd  [2];
   int         ifg_of   [2] = '{IFG_A, IFG_B};
   int         max_of   [2] = '{MAX_A, MAX_B};
   string      nm       [2] = '{"A", "B"};

   int n_cmp = 0;
   int n_bad = 0;
   int jab_seen = 0;
   int un_seen = 0;
   int pkts_done = 0;
   logic mid_rst_done = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of behaviour: a packet owner streams bytes (or underrun fillers), a finished
   // packet keeps the line quiet for IFG-1 further cycles, then an idle cycle picks the next port.
   task automatic model_step(input int d, input logic r);
      logic [9:0] w;
      logic [7:0] nd;
      logic       ne, ner, nun, njb, nbusy;
      int         p;
      exp_rd[d] = 2'b00;
      nd = 8'h00; ne = 1'b0; ner = 1'b0; nun = 1'b0; njb = 1'b0; nbusy = 1'b0;
      if (r) begin
         owner[d]    = -1;
         gap_left[d] = 0;
         grant_m[d]  = 1'b1;
      end else if (owner[d] >= 0) begin
         p     = owner[d];
         ne    = 1'b1;
         nbusy = 1'b1;
         if (!empty_v[d][p]) begin
            exp_rd[d][p] = 1'b1;
            w   = fq[d*2+p][0];
            nd  = w[7:0];
            ner = w[8] || (nb[d] >= max_of[d]);
            njb = (nb[d] == max_of[d]);
            nb[d]++;
            if (w[9]) begin
               owner[d]    = -1;
               gap_left[d] = ifg_of[d] - 1;
               pkts_done++;
            end
         end else begin
            ner = 1'b1;
            nun = 1'b1;
         end
      end else if (gap_left[d] > 0) begin
         gap_left[d]--;
         nbusy = (gap_left[d] > 0);
      end else begin
         if (avail_v[d] == 2'b11)  grant_m[d] = ~grant_m[d];
         else if (avail_v[d][0])   grant_m[d] = 1'b0;
         else if (avail_v[d][1])   grant_m[d] = 1'b1;
         if (avail_v[d] != 2'b00) begin
            owner[d] = grant_m[d] ? 1 : 0;
            nb[d]    = 0;
            nbusy    = 1'b1;
         end
      end
      if (d == 0 && njb) jab_seen++;
      if (d == 0 && nun) un_seen++;
      exp_obs[d] = {nd, ne, ner, grant_m[d], nbusy, nun, njb};
   endtask

   initial begin
      logic [13:0] o;
      logic [1:0]  rd;
      logic [9:0]  w;
      int          len;
      string       t;
      for (int d = 0; d < 2; d++) begin
         owner[d]    = -1;
         nb[d]       = 0;
         gap_left[d] = 0;
         grant_m[d]  = 1'b1;
         exp_obs[d]  = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         exp_rd[d]   = 2'b00;
         avail_v[d]  = 2'b00;
         empty_v[d]  = 2'b11;
         er_v[d]     = 2'b00;
         last_v[d]   = 2'b00;
         data_v[d][0] = 8'h00;
         data_v[d][1] = 8'h00;
      end
      for (int q = 0; q < 4; q++) pkt_cnt[q] = 0;
      rst = 1'b1;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         // retire the bytes popped at the edge just passed
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (exp_rd[d][p]) begin
                  w = fq[d*2+p].pop_front();
                  if (w[9]) pkt_cnt[d*2+p]--;
               end
            end
         end
         // registered outputs against the model's prediction for this cycle
         for (int d = 0; d < 2; d++) begin
            o = (d == 0) ? obs_a : obs_b;
            t = nm[d];
            check_val({t, " tx_data"},  32'(o[13:6]), 32'(exp_obs[d][13:6]));
            check_val({t, " tx_en"},    32'(o[5]),    32'(exp_obs[d][5]));
            check_val({t, " tx_er"},    32'(o[4]),    32'(exp_obs[d][4]));
            check_val({t, " grant"},    32'(o[3]),    32'(exp_obs[d][3]));
            check_val({t, " busy"},     32'(o[2]),    32'(exp_obs[d][2]));
            check_val({t, " underrun"}, 32'(o[1]),    32'(exp_obs[d][1]));
            check_val({t, " jabber"},   32'(o[0]),    32'(exp_obs[d][0]));
         end
         // new traffic: whole packets arrive atomically, random head stalls, random avail
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (cyc > 2 && $urandom_range(0, 7) == 0 && fq[d*2+p].size() < 40) begin
                  len = $urandom_range(1, 12);
                  for (int b = 0; b < len; b++) begin
                     w[7:0] = 8'($urandom);
                     w[8]   = ($urandom_range(0, 15) == 0);
                     w[9]   = (b == len - 1);
                     fq[d*2+p].push_back(w);
                  end
                  pkt_cnt[d*2+p]++;
               end
               empty_v[d][p] = (fq[d*2+p].size() == 0) || ($urandom_range(0, 9) == 0);
               if (fq[d*2+p].size() != 0) begin
                  w = fq[d*2+p][0];
                  data_v[d][p] = w[7:0];
                  er_v[d][p]   = w[8];
                  last_v[d][p] = w[9];
               end else begin
                  data_v[d][p] = 8'($urandom);
                  er_v[d][p]   = 1'($urandom);
                  last_v[d][p] = 1'($urandom);
               end
               avail_v[d][p] = (pkt_cnt[d*2+p] > 0) && ($urandom_range(0, 3) != 0);
            end
         end
         // reset once while instance A is about to pop the third byte of a packet
         rst = (cyc < 3);
         if (!mid_rst_done && cyc >= 1000 && owner[0] >= 0 && nb[0] == 2 && !empty_v[0][owner[0]]) begin
            rst = 1'b1;
            mid_rst_done = 1'b1;
         end
         model_step(0, rst);
         model_step(1, rst);
         #1;
         for (int d = 0; d < 2; d++) begin
            rd = (d == 0) ? rd_a : rd_b;
            check_val({nm[d], " p0_rd_en"}, 32'(rd[0]), 32'(exp_rd[d][0]));
            check_val({nm[d], " p1_rd_en"}, 32'(rd[1]), 32'(exp_rd[d][1]));
         end
      end

      check_val("mid_packet_reset_hit", 32'(mid_rst_done), 32'd1);
      check_val("jabber_exercised", 32'(jab_seen > 0), 32'd1);
      check_val("underrun_exercised", 32'(un_seen > 0), 32'd1);
      check_val("packets_completed", 32'(pkts_done > 50), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
